// File: rtl/dmem_pkg.sv
// Shared encodings and request checking for the byte-addressed data memory.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  // aw = log2 of the word depth; any set bit above the word index is out of range
  function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr,
                                     input int unsigned aw);
    logic mis, oor;
    mis = ((size == SIZE_HALF) && addr[0]) || ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
    oor = (addr >> (aw + 2)) != 32'd0;
    return mis || (size == SIZE_ILLEGAL) || oor;
  endfunction

endpackage

// File: rtl/load_extend_unit.sv
// Picks the addressed byte/half out of a 32-bit word and sign/zero extends it.
module load_extend_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{byte_offset, 3'b000} +: 8];
    sel_half = byte_offset[1] ? word[31:16] : word[15:0];
    result   = '0;
    case (size)
      SIZE_BYTE: result = is_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SIZE_HALF: result = is_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      SIZE_WORD: result = word;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// Byte-addressed data RAM with valid/ready requests, wait states, error checks
// and an optional post-reset clear sweep.
module data_memory_controller
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 128,
  parameter int WAIT_STATES    = 0,
  parameter int CLEAR_ON_RESET = 1
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state, state_nx;
  logic [AW-1:0] clr_cnt;
  logic [3:0]    wait_cnt;
  logic          out_en;
  logic [31:0]   pend_data;
  logic          pend_err;

  logic          accept, chk_err;
  logic [AW-1:0] widx;
  logic [31:0]   rword, ld_result, st_word;
  logic [3:0]    lane_en;

  // out_en keeps req_ready low through reset even when reset parks us in IDLE
  assign req_ready  = out_en && (state == IDLE);
  assign accept     = reset && req_valid && req_ready;
  assign chk_err    = req_error(req_size, address, AW);
  assign widx       = address[AW+1:2];
  assign rword      = mem[widx];

  assign resp_valid = (state == RESP);
  assign read_data  = (state == RESP) ? pend_data : '0;
  assign error      = (state == RESP) && pend_err;

  load_extend_unit u_ext (
    .word        (rword),
    .byte_offset (address[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .result      (ld_result)
  );

  // replicate the low-aligned store data onto every lane; lane_en picks the targets
  always_comb begin
    lane_en = 4'b0000;
    st_word = '0;
    case (req_size)
      SIZE_BYTE: begin lane_en = 4'b0001 << address[1:0]; st_word = {4{write_data[7:0]}}; end
      SIZE_HALF: begin lane_en = address[1] ? 4'b1100 : 4'b0011; st_word = {2{write_data[15:0]}}; end
      SIZE_WORD: begin lane_en = 4'b1111; st_word = write_data; end
      default:   begin lane_en = 4'b0000; st_word = '0; end
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR: if (&clr_cnt) state_nx = IDLE;
      IDLE:  if (accept) state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:  if (wait_cnt == 4'(WAIT_STATES - 1)) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt   <= '0;
      wait_cnt  <= '0;
      out_en    <= 1'b0;
      pend_data <= '0;
      pend_err  <= 1'b0;
    end else begin
      state  <= state_nx;
      out_en <= 1'b1;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept) begin
        wait_cnt  <= '0;
        pend_err  <= chk_err;
        pend_data <= (req_write || chk_err) ? '0 : ld_result;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // storage has no reset; only the sweep or an error-free store changes it
  always_ff @(posedge clock) begin
    if (reset && (state == CLEAR)) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_write && !chk_err) begin
      for (int k = 0; k < 4; k++)
        if (lane_en[k]) mem[widx][k*8 +: 8] <= st_word[k*8 +: 8];
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Randomized check of two controller configurations against a byte-array model.
module tb_data_memory_controller;

  logic        clock;
  logic        rst_a, rst_b;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] address, write_data;
  logic        ready_a, rv_a, err_a, ready_b, rv_b, err_b;
  logic [31:0] rd_a, rd_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit sel     = 0;  // 0: default config (A), 1: 16 words, 3 wait states, no sweep (B)

  logic [7:0] mdl_a [512];
  logic [7:0] mdl_b [64];

  data_memory_controller dut_a (
    .clock(clock), .reset(rst_a), .req_valid(req_valid), .req_ready(ready_a),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .address(address), .write_data(write_data), .resp_valid(rv_a),
    .read_data(rd_a), .error(err_a)
  );

  data_memory_controller #(.DEPTH_WORDS(16), .WAIT_STATES(3), .CLEAR_ON_RESET(0)) dut_b (
    .clock(clock), .reset(rst_b), .req_valid(req_valid), .req_ready(ready_b),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .address(address), .write_data(write_data), .resp_valid(rv_b),
    .read_data(rd_b), .error(err_b)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic        c_rdy(); return sel ? ready_b : ready_a; endfunction
  function automatic logic        c_rv();  return sel ? rv_b    : rv_a;    endfunction
  function automatic logic [31:0] c_rd();  return sel ? rd_b    : rd_a;    endfunction
  function automatic logic        c_err(); return sel ? err_b   : err_a;   endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mget(input int i);
    return sel ? mdl_b[i] : mdl_a[i];
  endfunction

  task automatic mput(input int i, input logic [7:0] v);
    if (sel) mdl_b[i] = v; else mdl_a[i] = v;
  endtask

  // expected response from the rules: byte array, little-endian, natural alignment
  task automatic model_step(input bit wr, input logic [1:0] sz, input bit uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] erd, output logic eer);
    int unsigned lim = sel ? 64 : 512;
    int nb = 1 << sz;
    logic [31:0] v, m;
    eer = (sz == 2'd3) || ((a % nb) != 0) || (a >= lim);
    erd = '0;
    if (!eer) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) mput(int'(a) + i, 8'(wd >> (8 * i)));
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(mget(int'(a) + i)) << (8 * i));
        if (!uns && nb < 4) begin
          m = (32'h1 << (8 * nb)) - 32'h1;
          if (v[8*nb-1]) v = v | ~m;
        end
        erd = v;
      end
    end
  endtask

  task automatic xact(input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int n = 0;
    int ws = sel ? 3 : 0;
    rd = '0; er = 1'b0;
    req_write = wr; req_size = sz; req_unsigned = uns; address = a; write_data = wd;
    req_valid = 1'b1;
    while (!c_rdy() && n < 300) begin @(negedge clock); n++; end
    if (!c_rdy()) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!c_rv() && n < 40);
    chk("resp_latency", n, ws + 1);
    rd = c_rd(); er = c_err();
    @(negedge clock);
    chk("resp_one_cycle", {31'b0, c_rv()}, 0);
    chk("rdata_idle_zero", c_rd(), 0);
  endtask

  task automatic op(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic        eer;
    model_step(wr, sz, uns, a, wd, erd, eer);
    xact(wr, sz, uns, a, wd, rd, er);
    chk({tag, "_rd"}, rd, erd);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, eer});
  endtask

  task automatic rand_op();
    int unsigned lim = sel ? 64 : 512;
    int unsigned r = $urandom % 10;
    logic [1:0]  sz = 2'($urandom);
    logic [31:0] a, rd;
    logic        er;
    if (r < 8)      a = $urandom_range(0, lim - 1);
    else if (r < 9) a = lim + $urandom_range(0, 15);
    else            a = $urandom;
    if (($urandom % 3) != 0 && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
    op("rand", 1'($urandom), sz, 1'($urandom), a, $urandom, rd, er);
  endtask

  task automatic count_sweep(input string tag, input int exp);
    int n = 0;
    do begin @(negedge clock); n++; end while (!c_rdy() && n < 400);
    chk(tag, n, exp);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    address = 0; write_data = 0;
    rst_a = 0; rst_b = 0;
    foreach (mdl_a[i]) mdl_a[i] = 8'h00;
    foreach (mdl_b[i]) mdl_b[i] = 8'h00;

    // ---------------- config A ----------------
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {31'b0, ready_a}, 0);
    chk("rst_rv",    {31'b0, rv_a},    0);
    chk("rst_rd",    rd_a,             0);
    chk("rst_err",   {31'b0, err_a},   0);
    rst_a = 1;
    count_sweep("sweep_len", 128);

    op("lw_first", 0, 2'b10, 0, 32'h10, 0, rd, er);
    chk("lw_first_c", rd, 32'h0);

    op("sw8", 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, rd, er);
    chk("sw8_rd0", rd, 32'h0);
    op("lb9", 0, 2'b00, 0, 32'h9, 0, rd, er);   chk("lb9_c",  rd, 32'hFFFFFFBE);
    op("lbu9", 0, 2'b00, 1, 32'h9, 0, rd, er);  chk("lbu9_c", rd, 32'h000000BE);
    op("lhA", 0, 2'b01, 0, 32'hA, 0, rd, er);   chk("lhA_c",  rd, 32'hFFFFDEAD);
    op("lhu8", 0, 2'b01, 1, 32'h8, 0, rd, er);  chk("lhu8_c", rd, 32'h0000BEEF);
    op("sbB", 1, 2'b00, 0, 32'hB, 32'h12345655, rd, er);
    op("lw8a", 0, 2'b10, 0, 32'h8, 0, rd, er);  chk("lw8a_c", rd, 32'h55ADBEEF);
    op("sh8", 1, 2'b01, 0, 32'h8, 32'h0000CAFE, rd, er);
    op("lw8b", 0, 2'b10, 0, 32'h8, 0, rd, er);  chk("lw8b_c", rd, 32'h55ADCAFE);

    op("lw6", 0, 2'b10, 0, 32'h6, 0, rd, er);   chk("lw6_err", {31'b0, er}, 1);
    op("sh3", 1, 2'b01, 0, 32'h3, 32'h1234, rd, er); chk("sh3_err", {31'b0, er}, 1);
    op("lw0", 0, 2'b10, 0, 32'h0, 0, rd, er);   chk("lw0_c", rd, 32'h0);
    op("lw200", 0, 2'b10, 0, 32'h200, 0, rd, er); chk("lw200_err", {31'b0, er}, 1);
    op("ill", 0, 2'b11, 0, 32'h0, 0, rd, er);   chk("ill_err", {31'b0, er}, 1);
    op("lw1FC", 0, 2'b10, 0, 32'h1FC, 0, rd, er); chk("lw1FC_err", {31'b0, er}, 0);

    repeat (150) rand_op();

    // reset partway through a sweep restarts it from word 0
    rst_a = 0;
    repeat (2) @(negedge clock);
    rst_a = 1;
    repeat (60) @(negedge clock);
    chk("mid_sweep_ready", {31'b0, ready_a}, 0);
    rst_a = 0;
    repeat (2) @(negedge clock);
    rst_a = 1;
    count_sweep("resweep_len", 128);
    foreach (mdl_a[i]) mdl_a[i] = 8'h00;
    op("post_sweep_lw8", 0, 2'b10, 0, 32'h8, 0, rd, er);
    chk("post_sweep_c", rd, 32'h0);
    repeat (20) rand_op();

    // ---------------- config B ----------------
    rst_a = 0;
    sel = 1;
    @(negedge clock);
    chk("b_rst_ready", {31'b0, ready_b}, 0);
    chk("b_rst_rv",    {31'b0, rv_b},    0);
    rst_b = 1;
    @(negedge clock);
    chk("b_ready_1cyc", {31'b0, ready_b}, 1);

    for (int w = 0; w < 16; w++) op("b_init", 1, 2'b10, 0, 32'(w * 4), $urandom, rd, er);
    repeat (60) rand_op();

    // req_valid held high: accept every 5 cycles, response 4 cycles after accept
    begin
      logic [31:0] erd;
      logic        eer;
      int last = -1;
      int acc  = 0;
      model_step(0, 2'b10, 0, 32'h4, 0, erd, eer);
      req_write = 0; req_size = 2'b10; req_unsigned = 0; address = 32'h4;
      req_valid = 1;
      for (int i = 0; i < 30; i++) begin
        if (rv_b) begin
          chk("ws_resp_lat", i - last, 4);
          chk("ws_resp_rd", rd_b, erd);
        end
        if (ready_b) begin
          if (last >= 0) chk("ws_acc_period", i - last, 5);
          last = i;
          acc++;
        end
        @(negedge clock);
      end
      req_valid = 0;
      chk("ws_accepts", acc, 6);
      repeat (6) @(negedge clock);
    end

    // reset during WAIT drops the pending response, contents survive
    begin
      int seen = 0;
      int n = 0;
      req_write = 0; req_size = 2'b10; req_unsigned = 0; address = 32'h8;
      req_valid = 1;
      while (!ready_b && n < 50) begin @(negedge clock); n++; end
      @(posedge clock);
      #1 req_valid = 0;
      @(negedge clock);
      rst_b = 0;
      repeat (3) begin @(negedge clock); if (rv_b) seen++; end
      chk("b_rst_hold_ready", {31'b0, ready_b}, 0);
      rst_b = 1;
      @(negedge clock);
      chk("b_rel_ready", {31'b0, ready_b}, 1);
      repeat (6) begin if (rv_b) seen++; @(negedge clock); end
      chk("abort_no_resp", seen, 0);
    end
    for (int w = 0; w < 16; w += 3) op("b_retain", 0, 2'b10, 0, 32'(w * 4), 0, rd, er);
    repeat (20) rand_op();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
